// File: rtl/config_sequencer.sv
// config_sequencer: replays staged per-block configuration bytes
// on the shared configId/configData bus with tracing suspended.
module config_sequencer #(
   parameter int         NUM_BLOCKS   = 8,
   parameter int         MAX_BYTES    = 16,
   parameter int         ID_BASE      = 0,
   parameter logic [7:0] IDLE_ID      = 8'hFF,
   parameter int         DRAIN_CYCLES = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           trace_en,
   input  logic                           cfg_wr_en,
   input  logic [$clog2(NUM_BLOCKS)-1:0]  cfg_wr_block,
   input  logic [$clog2(MAX_BYTES)-1:0]   cfg_wr_addr,
   input  logic [7:0]                     cfg_wr_data,
   input  logic                           cfg_len_we,
   input  logic [$clog2(MAX_BYTES+1)-1:0] cfg_len,
   input  logic                           start,
   output logic                           tracing,
   output logic [7:0]                     configId,
   output logic [7:0]                     configData,
   output logic                           busy,
   output logic                           done
);

   localparam int BW = $clog2(NUM_BLOCKS);
   localparam int AW = $clog2(MAX_BYTES);
   localparam int LW = $clog2(MAX_BYTES+1);
   localparam int CW = $clog2(DRAIN_CYCLES+1);

   typedef enum logic [2:0] {
      S_IDLE, S_DRAIN, S_SEND, S_GAP, S_DONE
   } state_t;

   state_t          r_state, w_ns;
   logic [BW-1:0]   r_blk, w_nblk, w_fblk;
   logic [AW-1:0]   r_idx, w_nidx;
   logic [CW-1:0]   r_cnt, w_ncnt;
   logic [BW:0]     w_from;
   logic            w_found;
   logic            w_wr_ok, w_len_ok;
   logic [LW-1:0]   w_len_clamped;
   logic [LW-1:0]   r_len [NUM_BLOCKS];
   logic [7:0]      r_mem [NUM_BLOCKS][MAX_BYTES];
   logic            w_tracing, w_busy, w_done;
   logic [7:0]      w_id, w_data;
   logic            r_tracing, r_busy, r_done;
   logic [7:0]      r_id, r_data;

   // Host writes land only while idle and inside the storage bounds
   assign w_wr_ok = (r_state == S_IDLE) && cfg_wr_en
                    && (32'(cfg_wr_block) < NUM_BLOCKS)
                    && (32'(cfg_wr_addr) < MAX_BYTES);
   assign w_len_ok = (r_state == S_IDLE) && cfg_len_we
                     && (32'(cfg_wr_block) < NUM_BLOCKS);
   assign w_len_clamped = (32'(cfg_len) > MAX_BYTES)
                          ? LW'(MAX_BYTES) : cfg_len;

   // Byte storage, deliberately without reset
   always_ff @(posedge clk) begin
      if (w_wr_ok)
         r_mem[cfg_wr_block][cfg_wr_addr] <= cfg_wr_data;
   end

   // Per-block lengths, cleared by reset so nothing replays
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NUM_BLOCKS; b++)
            r_len[b] <= '0;
      end else if (w_len_ok) begin
         r_len[cfg_wr_block] <= w_len_clamped;
      end
   end

   // Search starts at block 0 after drain, else after the current block
   assign w_from = (r_state == S_GAP)
                   ? ({1'b0, r_blk} + (BW+1)'(1)) : '0;

   // Lowest block at or above w_from that has bytes to send
   always_comb begin
      w_found = 1'b0;
      w_fblk  = '0;
      for (int b = NUM_BLOCKS-1; b >= 0; b--) begin
         if (b >= int'(w_from) && r_len[b] != '0) begin
            w_found = 1'b1;
            w_fblk  = BW'(b);
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_blk   <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_ns;
         r_blk   <= w_nblk;
         r_idx   <= w_nidx;
         r_cnt   <= w_ncnt;
      end
   end

   // Next-state logic
   always_comb begin
      w_ns   = r_state;
      w_nblk = r_blk;
      w_nidx = r_idx;
      w_ncnt = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_ns   = S_DRAIN;
               w_ncnt = '0;
            end
         end
         S_DRAIN, S_GAP: begin
            if (r_state == S_DRAIN
                && r_cnt != CW'(DRAIN_CYCLES-1)) begin
               w_ncnt = r_cnt + CW'(1);
            end else if (w_found) begin
               w_ns   = S_SEND;
               w_nblk = w_fblk;
               w_nidx = '0;
            end else begin
               w_ns = S_DONE;
            end
         end
         S_SEND: begin
            if (LW'(r_idx) + LW'(1) >= r_len[r_blk])
               w_ns = S_GAP;
            else
               w_nidx = r_idx + AW'(1);
         end
         S_DONE:  w_ns = S_IDLE;
         default: w_ns = S_IDLE;
      endcase
   end

   // Output values for the state being entered
   always_comb begin
      w_tracing = (w_ns == S_IDLE) ? trace_en : 1'b0;
      w_busy    = (w_ns != S_IDLE);
      w_done    = (w_ns == S_DONE);
      w_id      = IDLE_ID;
      w_data    = '0;
      if (w_ns == S_SEND) begin
         w_id   = 8'(ID_BASE) + 8'(w_nblk);
         w_data = r_mem[w_nblk][w_nidx];
      end
   end

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tracing <= 1'b0;
         r_id      <= IDLE_ID;
         r_data    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_tracing <= w_tracing;
         r_id      <= w_id;
         r_data    <= w_data;
         r_busy    <= w_busy;
         r_done    <= w_done;
      end
   end

   assign tracing    = r_tracing;
   assign configId   = r_id;
   assign configData = r_data;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_config_sequencer.sv
// tb_config_sequencer: directed table, corner sequences and
// randomized traffic against a transaction-level model.
module tb_config_sequencer;

   localparam int NB = 8;
   localparam int MB = 16;
   localparam int D  = 4;
   localparam int IB = 0;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       trace_en = 1'b0;
   logic       cfg_wr_en = 1'b0;
   logic [2:0] cfg_wr_block = '0;
   logic [3:0] cfg_wr_addr = '0;
   logic [7:0] cfg_wr_data = '0;
   logic       cfg_len_we = 1'b0;
   logic [4:0] cfg_len = '0;
   logic       start = 1'b0;
   logic       tracing, busy, done;
   logic [7:0] configId, configData;

   always #5 clk = ~clk;

   config_sequencer dut (
      .clk(clk), .rst(rst), .trace_en(trace_en),
      .cfg_wr_en(cfg_wr_en), .cfg_wr_block(cfg_wr_block),
      .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
      .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
      .start(start), .tracing(tracing),
      .configId(configId), .configData(configData),
      .busy(busy), .done(done)
   );

   typedef struct packed {
      logic       tr;
      logic [7:0] id;
      logic [7:0] d;
      logic       bz;
      logic       dn;
   } out_t;

   typedef struct packed {
      logic       te;
      logic       we;
      logic [3:0] addr;
      logic [7:0] dat;
      logic       lwe;
      logic [4:0] len;
      logic       st;
      out_t       exp;
   } vec_t;

   int         n_chk = 0;
   int         n_fail = 0;
   int         mlen [NB];
   logic [7:0] mmem [NB][MB];
   out_t       q [$];
   out_t       exp_o;
   logic [7:0] cap [$];
   logic [7:0] ids [$];
   int         ndone, done_at;
   vec_t       tbl [12];

   function automatic out_t mk(logic tr, logic [7:0] id,
                               logic [7:0] d, logic bz,
                               logic dn);
      mk = {tr, id, d, bz, dn};
   endfunction

   function automatic vec_t v(logic te, logic we,
                              logic [3:0] a, logic [7:0] dat,
                              logic lwe, logic [4:0] len,
                              logic st, out_t e);
      v = {te, we, a, dat, lwe, len, st, e};
   endfunction

   function automatic out_t dut_o();
      dut_o = {tracing, configId, configData, busy, done};
   endfunction

   function automatic void check(string name,
                                 logic [31:0] got,
                                 logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h",
                  name, got, want);
      end
   endfunction

   function automatic void model_reset();
      foreach (mlen[b]) mlen[b] = 0;
      q.delete();
      exp_o = mk(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
   endfunction

   // A start expands into the full list of bus cycles at once
   function automatic void model_edge();
      if (!exp_o.bz) begin
         if (cfg_wr_en && int'(cfg_wr_addr) < MB)
            mmem[cfg_wr_block][cfg_wr_addr] = cfg_wr_data;
         if (cfg_len_we)
            mlen[cfg_wr_block] =
               (int'(cfg_len) > MB) ? MB : int'(cfg_len);
         if (start) begin
            repeat (D) q.push_back(mk(0, 8'hFF, 0, 1, 0));
            for (int b = 0; b < NB; b++) begin
               for (int i = 0; i < mlen[b]; i++)
                  q.push_back(mk(0, 8'(IB + b),
                                 mmem[b][i], 1, 0));
               if (mlen[b] > 0)
                  q.push_back(mk(0, 8'hFF, 0, 1, 0));
            end
            q.push_back(mk(0, 8'hFF, 0, 1, 1));
         end
      end
      if (q.size() > 0) exp_o = q.pop_front();
      else exp_o = mk(trace_en, 8'hFF, 0, 0, 0);
   endfunction

   task automatic cyc();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      @(negedge clk);
      check("model", dut_o(), exp_o);
      n_chk++;
      if (tracing === 1'b1 && configId !== 8'hFF) begin
         n_fail++;
         $display("FAIL trace_id: tracing=1 id=%h", configId);
      end
   endtask

   task automatic clr();
      cfg_wr_en  = 1'b0;
      cfg_len_we = 1'b0;
      start      = 1'b0;
   endtask

   task automatic wr_byte(int b, int a, logic [7:0] d);
      cfg_wr_en    = 1'b1;
      cfg_wr_block = 3'(b);
      cfg_wr_addr  = 4'(a);
      cfg_wr_data  = d;
      cyc();
      clr();
   endtask

   task automatic set_len(int b, int l);
      cfg_len_we   = 1'b1;
      cfg_wr_block = 3'(b);
      cfg_len      = 5'(l);
      cyc();
      clr();
   endtask

   // Runs one sequence, capturing bytes for one ID
   task automatic seq_capture(logic [7:0] id, int rt1, int rt2);
      cap.delete();
      ids.delete();
      ndone   = 0;
      done_at = -1;
      for (int n = 0; n < 300; n++) begin
         start = (n == 0) || (n == rt1) || (n == rt2);
         cyc();
         start = 1'b0;
         if (busy) ids.push_back(configId);
         if (busy && configId == id)
            cap.push_back(configData);
         if (done) begin
            ndone++;
            if (done_at < 0) done_at = n + 1;
         end
         if (!busy) break;
      end
      check("seq_end_busy", 32'(busy), 0);
   endtask

   logic [7:0] exp_ids [11];

   initial begin
      tbl[0]  = v(1,1,0,8'h03,0,0,0, mk(1,8'hFF,0,0,0));
      tbl[1]  = v(1,1,1,8'h01,1,2,0, mk(1,8'hFF,0,0,0));
      tbl[2]  = v(1,0,0,8'h00,0,0,1, mk(0,8'hFF,0,1,0));
      tbl[3]  = v(1,0,0,8'h00,0,0,0, mk(0,8'hFF,0,1,0));
      tbl[4]  = v(1,0,0,8'h00,0,0,0, mk(0,8'hFF,0,1,0));
      tbl[5]  = v(1,0,0,8'h00,0,0,0, mk(0,8'hFF,0,1,0));
      tbl[6]  = v(1,0,0,8'h00,0,0,0, mk(0,8'h00,8'h03,1,0));
      tbl[7]  = v(1,0,0,8'h00,0,0,0, mk(0,8'h00,8'h01,1,0));
      tbl[8]  = v(1,0,0,8'h00,0,0,0, mk(0,8'hFF,0,1,0));
      tbl[9]  = v(1,0,0,8'h00,0,0,0, mk(0,8'hFF,0,1,1));
      tbl[10] = v(1,0,0,8'h00,0,0,0, mk(1,8'hFF,0,0,0));
      tbl[11] = v(0,0,0,8'h00,0,0,0, mk(0,8'hFF,0,0,0));
      exp_ids = '{8'hFF, 8'hFF, 8'hFF, 8'hFF,
                  8'h01, 8'h01, 8'h01, 8'hFF,
                  8'h03, 8'hFF, 8'hFF};

      model_reset();
      #1 rst = 1'b1;
      #1;
      check("reset_out", 32'(dut_o()),
            32'(mk(0, 8'hFF, 0, 0, 0)));
      @(negedge clk);
      rst = 1'b0;

      // single block, cycle-exact table
      for (int i = 0; i < 12; i++) begin
         trace_en     = tbl[i].te;
         cfg_wr_en    = tbl[i].we;
         cfg_wr_block = 3'd0;
         cfg_wr_addr  = tbl[i].addr;
         cfg_wr_data  = tbl[i].dat;
         cfg_len_we   = tbl[i].lwe;
         cfg_len      = tbl[i].len;
         start        = tbl[i].st;
         cyc();
         check($sformatf("tbl[%0d]", i),
               32'(dut_o()), 32'(tbl[i].exp));
      end
      clr();

      // zero-length blocks are skipped
      wr_byte(1, 0, 8'h11);
      wr_byte(1, 1, 8'h12);
      wr_byte(1, 2, 8'h13);
      wr_byte(3, 0, 8'h31);
      set_len(0, 0);
      set_len(1, 3);
      set_len(3, 1);
      seq_capture(8'h01, -1, -1);
      check("skip_len", ids.size(), 11);
      for (int i = 0; i < 11; i++)
         check($sformatf("skip_id[%0d]", i),
               32'(ids[i]), 32'(exp_ids[i]));
      check("skip_b1_last", 32'(cap[2]), 32'h13);

      // writes while busy are dropped
      set_len(0, 2);
      set_len(1, 0);
      set_len(3, 0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      wr_byte(0, 0, 8'hAA);
      set_len(0, 5);
      for (int n = 0; n < 100 && busy; n++) cyc();
      seq_capture(8'h00, -1, -1);
      check("blk_cnt", cap.size(), 2);
      check("blk_b0", 32'(cap[0]), 32'h03);
      check("blk_b1", 32'(cap[1]), 32'h01);

      // length clamp
      set_len(0, 0);
      for (int a = 0; a < MB; a++) wr_byte(2, a, 8'(a*7 + 1));
      set_len(2, 20);
      seq_capture(8'h02, -1, -1);
      check("clamp_cnt", cap.size(), 16);
      check("clamp_first", 32'(cap[0]), 32'h01);
      check("clamp_last", 32'(cap[15]), 32'h6A);

      // start during drain and send is ignored
      seq_capture(8'h02, 2, 8);
      check("retrig_done", ndone, 1);
      check("retrig_cnt", cap.size(), 16);

      // asynchronous reset in the middle of a send
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int n = 0; n < 20 && configId == 8'hFF; n++) cyc();
      check("in_send", 32'(configId != 8'hFF), 1);
      #2 rst = 1'b1;
      #1;
      check("rst_id", 32'(configId), 32'hFF);
      check("rst_tr", 32'(tracing), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      model_reset();
      cyc();
      rst = 1'b0;
      seq_capture(8'h02, -1, -1);
      check("rst_done_at", done_at, D + 1);
      check("rst_nothing", cap.size(), 0);

      // randomized traffic
      trace_en = 1'b1;
      for (int b = 0; b < NB; b++)
         for (int a = 0; a < MB; a++)
            wr_byte(b, a, 8'($urandom));
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 7) == 0) trace_en = ~trace_en;
         cfg_wr_en    = ($urandom_range(0, 3) == 0);
         cfg_wr_block = 3'($urandom);
         cfg_wr_addr  = 4'($urandom);
         cfg_wr_data  = 8'($urandom);
         cfg_len_we   = ($urandom_range(0, 5) == 0);
         cfg_len      = 5'($urandom_range(0, 20));
         start        = ($urandom_range(0, 14) == 0);
         cyc();
      end
      clr();
      for (int n = 0; n < 300 && busy; n++) cyc();
      check("final_idle", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
